// File: rtl/sr_bank_if.sv
// Target-word handshake between the sequencer (master) and sr_bank_driver (slave).
interface sr_bank_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sr_bank_driver.sv
// Converts target words into S/R excitation for an SR flip-flop bank and verifies Q.
// Optional feature macro SR_DRV_RETRY_EN: one retry of a failed check before flagging an error.
module sr_bank_driver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             RST,
   sr_bank_if.slave         bus,
   input  logic [WIDTH-1:0] q_fb,
   input  logic             err_clr,
   output logic [WIDTH-1:0] S_out,
   output logic [WIDTH-1:0] R_out,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] err_bits
);

   typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] err_bits_q, err_bits_d;
   logic [WIDTH-1:0] mism;
`ifdef SR_DRV_RETRY_EN
   logic             retry_q, retry_d;
`endif

   assign mism = q_fb ^ target_q;

   always_comb begin
      state_d    = state_q;
      target_d   = target_q;
      s_d        = '0;
      r_d        = '0;
      done_d     = 1'b0;
      err_d      = err_q;
      err_bits_d = err_bits_q;
`ifdef SR_DRV_RETRY_EN
      retry_d    = retry_q;
`endif
      if (err_clr) begin
         err_d      = 1'b0;
         err_bits_d = '0;
      end
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               // S and R are mutually exclusive per bit by construction.
               target_d = bus.in_data;
               s_d      = bus.in_data & ~q_fb;
               r_d      = ~bus.in_data & q_fb;
               state_d  = APPLY;
`ifdef SR_DRV_RETRY_EN
               retry_d  = 1'b0;
`endif
            end
         end
         APPLY: state_d = CHECK;
         CHECK: begin
            if (mism == '0) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
`ifdef SR_DRV_RETRY_EN
            else if (!retry_q) begin
               retry_d = 1'b1;
               s_d     = target_q & ~q_fb;
               r_d     = ~target_q & q_fb;
               state_d = APPLY;
            end
`endif
            else begin
               // A fresh error overrides a simultaneous clear.
               err_d      = 1'b1;
               err_bits_d = err_clr ? mism : (err_bits_q | mism);
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q    <= IDLE;
         s_q        <= '0;
         r_q        <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_bits_q <= '0;
`ifdef SR_DRV_RETRY_EN
         retry_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         r_q        <= r_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_bits_q <= err_bits_d;
`ifdef SR_DRV_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      target_q <= target_d;
   end

   assign S_out        = s_q;
   assign R_out        = r_q;
   assign done         = done_q;
   assign err          = err_q;
   assign err_bits     = err_bits_q;
   assign busy         = (state_q != IDLE);
   assign bus.in_ready = (state_q == IDLE);

endmodule

// File: tb/tb_sr_bank_driver.sv
// Scoreboard bench for sr_bank_driver with a behavioural SR bank (optional stuck-at-0 bits).
module tb_sr_bank_driver;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] s;
      logic [W-1:0] r;
      int           lat;
      int           exc;
      logic         err;
      logic [W-1:0] bits;
   } exp_t;

   logic         clk = 1'b0;
   logic         RST = 1'b0;
   logic [W-1:0] q_fb;
   logic         err_clr = 1'b0;
   logic [W-1:0] S_out, R_out, err_bits;
   logic         busy, done, err;
   logic [W-1:0] bank_q;
   logic [W-1:0] stuck0 = '0;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t sb[$];

   sr_bank_if #(.WIDTH(W)) bus ();

   sr_bank_driver #(.WIDTH(W)) dut (
      .clk(clk), .RST(RST), .bus(bus), .q_fb(q_fb), .err_clr(err_clr),
      .S_out(S_out), .R_out(R_out), .busy(busy), .done(done),
      .err(err), .err_bits(err_bits)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge RST) begin
      if (!RST) bank_q <= '0;
      else      bank_q <= ((bank_q | S_out) & ~R_out) & ~stuck0;
   end
   assign q_fb = bank_q;

   always @(negedge clk) begin
      n_checks++;
      if ((S_out & R_out) !== '0) begin
         n_fail++;
         $display("FAIL s_and_r: S=%h R=%h overlap, required 00", S_out, R_out);
      end
   end

`ifdef SR_DRV_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   // Push the expected outcome of sending data against the current bank state.
   task automatic push_exp(input logic [W-1:0] data);
      exp_t e;
      logic fails;
      e.s   = data & ~bank_q;
      e.r   = ~data & bank_q;
      fails = ((data & stuck0) != '0);
      e.lat = (fails && RETRY) ? 4 : 2;
      e.exc = ((e.s | e.r) == '0) ? 0 : ((fails && RETRY) ? 2 : 1);
      e.err = fails;
      e.bits = data & stuck0;
      sb.push_back(e);
   endtask

   task automatic send(input logic [W-1:0] data, input int clr_at,
                       output logic [W-1:0] s0, output logic [W-1:0] r0,
                       output int lat, output int exc,
                       output logic e, output logic [W-1:0] eb);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = ~data;
      s0  = S_out;
      r0  = R_out;
      exc = ((s0 | r0) != '0) ? 1 : 0;
      lat = -1;
      e   = 1'bx;
      eb  = 'x;
      for (int k = 0; k < 20; k++) begin
         if (k == clr_at) err_clr = 1'b1;
         @(negedge clk);
         err_clr = 1'b0;
         if ((S_out | R_out) != '0) exc++;
         if (done === 1'b1) begin
            lat = k + 1;
            e   = err;
            eb  = err_bits;
            break;
         end
      end
   endtask

   task automatic run_word(input string name, input logic [W-1:0] data, input int clr_at);
      logic [W-1:0] s0, r0, eb;
      int lat, exc;
      logic e;
      exp_t x;
      push_exp(data);
      send(data, clr_at, s0, r0, lat, exc, e, eb);
      x = sb.pop_front();
      n_checks++;
      if (s0 !== x.s) begin n_fail++; $display("FAIL %s_s: got %h required %h", name, s0, x.s); end
      n_checks++;
      if (r0 !== x.r) begin n_fail++; $display("FAIL %s_r: got %h required %h", name, r0, x.r); end
      n_checks++;
      if (lat !== x.lat) begin n_fail++; $display("FAIL %s_done_latency: got %0d required %0d", name, lat, x.lat); end
      n_checks++;
      if (exc !== x.exc) begin n_fail++; $display("FAIL %s_excitations: got %0d required %0d", name, exc, x.exc); end
      n_checks++;
      if (e !== x.err) begin n_fail++; $display("FAIL %s_err: got %b required %b", name, e, x.err); end
      n_checks++;
      if (eb !== x.bits) begin n_fail++; $display("FAIL %s_err_bits: got %h required %h", name, eb, x.bits); end
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if ({S_out, R_out, done, err, err_bits, busy, bus.in_ready} !== {8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_in: S=%h R=%h done=%b err=%b bits=%h busy=%b rdy=%b required 00 00 0 0 00 0 1",
                  S_out, R_out, done, err, err_bits, busy, bus.in_ready);
      end
      RST = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({busy, bus.in_ready, done} !== 3'b010) begin
         n_fail++;
         $display("FAIL reset_out: busy=%b rdy=%b done=%b required 0 1 0", busy, bus.in_ready, done);
      end
   endtask

   task automatic test_set_pattern();
      run_word("set_a5", 8'hA5, -1);
      n_checks++;
      if (bank_q !== 8'hA5) begin n_fail++; $display("FAIL set_a5_bank: got %h required a5", bank_q); end
   endtask

   task automatic test_mixed_pattern();
      run_word("mix_3c", 8'h3C, -1);
   endtask

   task automatic test_hold_pattern();
      run_word("hold_3c", 8'h3C, -1);
   endtask

   task automatic test_stuck_bit();
      stuck0 = 8'h01;
      run_word("stuck", 8'h01, -1);
   endtask

   task automatic test_err_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      n_checks++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b required 0", err); end
      n_checks++;
      if (err_bits !== 8'h00) begin n_fail++; $display("FAIL clr_bits: got %h required 00", err_bits); end
      run_word("stuck_clr", 8'h01, RETRY ? 3 : 1);
      stuck0 = '0;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = ~bank_q;
      @(posedge clk);
      bus.in_valid = 1'b0;
      #2;
      RST = 1'b0;
      #1;
      n_checks++;
      if ((S_out | R_out) !== 8'h00) begin
         n_fail++;
         $display("FAIL arst_sr: S=%h R=%h required 00 00", S_out, R_out);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done_in: got %b required 0", done); end
      end
      RST = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_checks++;
         if ({done, busy, bus.in_ready, err} !== 4'b0010) begin
            n_fail++;
            $display("FAIL arst_after: done=%b busy=%b rdy=%b err=%b required 0 0 1 0", done, busy, bus.in_ready, err);
         end
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      test_reset();
      test_set_pattern();
      test_mixed_pattern();
      test_hold_pattern();
      test_stuck_bit();
      test_err_clr();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
